coord_fetch: RTL and testbench
==============================

// Module: coord_fetch
// PURPOSE
//  Reader/initiator for the synchronous coordinate ROM (1-cycle registered read, 16-bit x/z per address).
//  On a start pulse, walks ROM addresses 0..NUM_POINTS-1 and streams each (x, z) pair downstream on a valid/ready interface.
//  Absorbs the ROM read latency and downstream backpressure with a 2-entry buffer, so no coordinate is dropped or duplicated.
//  Sits between the coordinate ROM and the beamforming delay calculator.
// PARAMETERS
//  NUM_POINTS  16                     number of ROM entries to scan (>=1)
//  ADDR_WIDTH  $clog2(NUM_POINTS)     ROM address width (NUM_POINTS==1 -> treat as 1)
//  COORD_W     16                     width of x and z words
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous reset, active-high
//  start      in   1           1-cycle pulse: begin scan; ignored while busy
//  busy       out  1           high from accepted start until last beat accepted
//  done       out  1           1-cycle pulse the cycle after the last beat handshakes
//  rom_addr   out  ADDR_WIDTH  address to ROM
//  rom_x      in   COORD_W     ROM x data, valid 1 cycle after rom_addr sampled
//  rom_z      in   COORD_W     ROM z data, valid 1 cycle after rom_addr sampled
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts when out_valid & out_ready
//  out_x      out  COORD_W     x coordinate of beat
//  out_z      out  COORD_W     z coordinate of beat
//  out_idx    out  ADDR_WIDTH  ROM index of beat
//  out_last   out  1           high on beat with out_idx == NUM_POINTS-1
// BEHAVIOUR
//  - Reset: busy=0, done=0, out_valid=0, out_x/out_z/out_idx=0, out_last=0, rom_addr=0; buffer emptied, FSM->IDLE.
//  - FSM: IDLE -(start)-> RUN; RUN -(last address issued)-> DRAIN; DRAIN -(last beat accepted)-> DONE; DONE -> IDLE (done=1 here, 1 cycle).
//  - Read issue: a read "issues" in cycle t when RUN and (buf_count + inflight) < 2; rom_addr holds the issued index, ROM data captured into buffer at t+1 (inflight flag tracks it).
//  - Issue counter increments per issue; after issuing NUM_POINTS-1 -> DRAIN, no further issues; rom_addr holds last value.
//  - Index of each returned word is carried alongside (tag register), written into buffer with x/z.
//  - Buffer: 2-entry FIFO, head drives out_*; out_valid = !empty. Push and pop in same cycle allowed; count unchanged.
//  - out_* stable while out_valid & !out_ready (AXI-style; no retraction, no change).
//  - Throughput: with out_ready held high, one beat per cycle after 2-cycle initial latency (start@0 -> first out_valid@2).
//  - start while busy: ignored, no restart. start same cycle as done: ignored (busy still high in DONE).
//  - Reset mid-scan: everything returns to reset values next cycle; in-flight ROM data discarded; no done pulse.
//  - NUM_POINTS==1: single beat with out_last=1, out_idx=0.
//  - Index/counter widths: ADDR_WIDTH bits; counter never wraps (stops at NUM_POINTS-1).
// STRUCTURE
//  - Shared package beam_pkg: COORD_W, coord_t {x,z} struct/typedef, fetch FSM state enum (IDLE,RUN,DRAIN,DONE).
//  - One sub-module: coord_skid_fifo (2-entry, data={idx,x,z}, push/pop/count/empty/full); top holds FSM, issue counter, inflight tag.
// TESTING (bench uses behavioural ROM model with 1-cycle latency, x[i]=16'h1000+i, z[i]=16'h2000+i)
//  1. NUM_POINTS=16, out_ready=1, start@0 -> out_valid@2..17, out_idx 0..15, out_x 0x1000..0x100F, out_last@17, done@18, busy low@19.
//  2. out_ready=0 for 20 cycles after start -> exactly 2 reads issued, beat idx0 held stable; release -> idx0..15 in order, no gaps/dups.
//  3. out_ready toggling 1010... -> all 16 beats delivered once, in order; payload never changes while valid&!ready.
//  4. start pulsed again at cycle 5 mid-scan -> ignored; exactly 16 beats and one done pulse.
//  5. rst asserted at cycle 8 for 1 cycle -> next cycle all outputs zero, no done; new start -> clean scan from idx0.
//  6. NUM_POINTS=1 -> one beat idx0 x=0x1000 z=0x2000 out_last=1, done next cycle after handshake.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared types for the beamforming front end.
//   COORD_W        default width of one coordinate word
//   coord_t        one (x, z) coordinate pair
//   fetch_state_t  state of the coordinate fetch controller
package beam_pkg;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] z;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/coord_skid_fifo.sv
// Two-entry FIFO that absorbs ROM read latency and downstream stalls.
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push, din  write one word; accepted when not full, or when full and popping
//   pop        remove head word; ignored when empty
//   dout       head word (meaningful only while !empty)
//   count      number of stored words (0..2)
//   empty/full occupancy flags
module coord_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/coord_fetch.sv
// Coordinate ROM reader: on start, reads ROM addresses 0..NUM_POINTS-1 and
// streams each (x, z) pair with its index on a valid/ready interface.
//   clk, rst            clock, synchronous active-high reset
//   start / busy / done scan control: start pulse, scan in progress, 1-cycle done
//   rom_addr            address presented to the 1-cycle-latency ROM
//   rom_x, rom_z        ROM read data for the address sampled one edge earlier
//   out_valid/out_ready output handshake
//   out_x, out_z        coordinate payload of the head beat
//   out_idx, out_last   ROM index of the beat, high on index NUM_POINTS-1
module coord_fetch #(
  parameter int NUM_POINTS = 16,
  parameter int ADDR_WIDTH = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1,
  parameter int COORD_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COORD_W-1:0]    rom_x,
  input  logic [COORD_W-1:0]    rom_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_z,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last
);

  import beam_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_POINTS - 1);
  localparam int                    FW       = ADDR_WIDTH + 2 * COORD_W;

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [ADDR_WIDTH-1:0] issue_cnt;
  logic                  rd_vld_p1;
  logic [ADDR_WIDTH-1:0] rd_idx_p1;
  logic [1:0]            buf_count;
  logic                  buf_empty;
  logic                  buf_full;
  logic [FW-1:0]         buf_dout;
  logic [2:0]            occ_next;
  logic                  accepting;
  logic                  issue;
  logic                  pop;
  logic                  last_issue;

  // The ROM samples rom_addr on the same edge that issues it, so the start
  // cycle itself can issue address 0 (first beat two cycles after start).
  assign accepting  = (state == RUN) || (state == IDLE && start);
  assign pop        = out_valid && out_ready;
  // Occupancy after this edge: a word popped now frees room for the word
  // issued now, which lands in the buffer one edge later.
  assign occ_next   = {1'b0, buf_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign issue      = accepting && !(buf_full && !pop) && (occ_next < 3'd2);
  assign last_issue = issue && (issue_cnt == LAST_IDX);
  assign rom_addr   = issue_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (last_issue) state_nxt = DRAIN;
               else if (start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= issue;
      if (state == DONE) issue_cnt <= '0;
      else if (issue && !last_issue) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // ---- p1: ROM read in flight, index tag travels with it ----
  always_ff @(posedge clk) begin
    if (issue) rd_idx_p1 <= issue_cnt;
  end

  coord_skid_fifo #(
    .DATA_W (FW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld_p1),
    .pop   (pop),
    .din   ({rd_idx_p1, rom_x, rom_z}),
    .dout  (buf_dout),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // ---- p2: buffer head drives the output beat ----
  assign out_valid = !buf_empty;
  assign {out_idx, out_x, out_z} = out_valid ? buf_dout : '0;
  assign out_last  = out_valid && (out_idx == LAST_IDX);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_coord_fetch.sv
module tb_coord_fetch;

  logic clk;
  logic rst;

  // DUT A: 16 points
  logic        start_a, busy_a, done_a;
  logic [3:0]  rom_addr_a, out_idx_a;
  logic [15:0] rom_x_a, rom_z_a, out_x_a, out_z_a;
  logic        out_valid_a, out_ready_a, out_last_a;

  // DUT B: 1 point
  logic        start_b, busy_b, done_b;
  logic [0:0]  rom_addr_b, out_idx_b;
  logic [15:0] rom_x_b, rom_z_b, out_x_b, out_z_b;
  logic        out_valid_b, out_ready_b, out_last_b;

  coord_fetch #(.NUM_POINTS(16), .ADDR_WIDTH(4), .COORD_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rom_addr(rom_addr_a), .rom_x(rom_x_a), .rom_z(rom_z_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_x(out_x_a),
    .out_z(out_z_a), .out_idx(out_idx_a), .out_last(out_last_a)
  );

  coord_fetch #(.NUM_POINTS(1), .ADDR_WIDTH(1), .COORD_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rom_addr(rom_addr_b), .rom_x(rom_x_b), .rom_z(rom_z_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_x(out_x_b),
    .out_z(out_z_b), .out_idx(out_idx_b), .out_last(out_last_b)
  );

  // Behavioural ROMs: 1-cycle registered read, x[i]=0x1000+i, z[i]=0x2000+i
  always @(posedge clk) begin
    rom_x_a <= 16'h1000 + {12'd0, rom_addr_a};
    rom_z_a <= 16'h2000 + {12'd0, rom_addr_a};
    rom_x_b <= 16'h1000 + {15'd0, rom_addr_b};
    rom_z_b <= 16'h2000 + {15'd0, rom_addr_b};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard for DUT A: expected stream is idx 0..15 in order
  int          exp_next;
  int          beats;
  int          done_cnt;
  bit          stall_prev;
  logic [35:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sb_reset();
    exp_next   = 0;
    beats      = 0;
    done_cnt   = 0;
    stall_prev = 0;
    held       = '0;
  endtask

  task automatic monitor_a();
    if (stall_prev) begin
      chk("hold_valid", out_valid_a, 1);
      chk("hold_payload", {out_idx_a, out_x_a, out_z_a}, held);
    end
    if (out_valid_a && out_ready_a) begin
      chk("beat_idx", out_idx_a, exp_next);
      chk("beat_x", out_x_a, 16'h1000 + exp_next);
      chk("beat_z", out_z_a, 16'h2000 + exp_next);
      chk("beat_last", out_last_a, (exp_next == 15));
      exp_next++;
      beats++;
    end
    stall_prev = out_valid_a && !out_ready_a && !rst;
    held       = {out_idx_a, out_x_a, out_z_a};
    if (done_a) done_cnt++;
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are observed
  // on the falling edge by the monitor and 1 unit after the edge by callers.
  task automatic step();
    @(negedge clk);
    monitor_a();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2 == 0);
      2:       return ($urandom_range(0, 99) < 60);
      3:       return (c >= 20);
      default: return 1'b1;
    endcase
  endfunction

  // One full scan on DUT A with a given backpressure pattern; start is
  // re-pulsed at cycle restart_at (negative = never).
  task automatic run_scan(input string tag, input int mode, input int restart_at);
    bit finished;
    sb_reset();
    start_a     = 1'b1;
    out_ready_a = pick(mode, 0);
    step();
    start_a  = 1'b0;
    finished = 0;
    for (int c = 1; c < 400 && !finished; c++) begin
      if (mode == 3 && c == 20) begin
        chk({tag, "_stall_addr"}, rom_addr_a, 2);
        chk({tag, "_stall_valid"}, out_valid_a, 1);
        chk({tag, "_stall_idx"}, out_idx_a, 0);
        chk({tag, "_stall_beats"}, beats, 0);
      end
      out_ready_a = pick(mode, c);
      start_a     = (c == restart_at);
      step();
      start_a = 1'b0;
      if (!busy_a) finished = 1;
    end
    chk({tag, "_finished"}, finished, 1);
    out_ready_a = 1'b1;
    repeat (3) step();
    chk({tag, "_beats"}, beats, 16);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_idle"}, busy_a, 0);
  endtask

  typedef struct {
    int cyc;
    bit valid;
    int idx;
    bit last;
    bit done;
    bit busy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].cyc   = i + 1;
      tbl[i].valid = (tbl[i].cyc >= 2 && tbl[i].cyc <= 17);
      tbl[i].idx   = tbl[i].cyc - 2;
      tbl[i].last  = (tbl[i].cyc == 17);
      tbl[i].done  = (tbl[i].cyc == 18);
      tbl[i].busy  = (tbl[i].cyc >= 1 && tbl[i].cyc <= 18);
    end

    rst = 1'b1; start_a = 0; start_b = 0; out_ready_a = 0; out_ready_b = 0;
    sb_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_payload", {out_idx_a, out_x_a, out_z_a, out_last_a}, 0);
    chk("rst_addr", rom_addr_a, 0);
    chk("rst_b_valid", {busy_b, done_b, out_valid_b, out_last_b}, 0);

    // Full-rate scan against the cycle table
    sb_reset();
    start_a = 1'b1; out_ready_a = 1'b1;
    step();
    start_a = 1'b0;
    foreach (tbl[i]) begin
      chk("t1_valid", out_valid_a, tbl[i].valid);
      if (tbl[i].valid) chk("t1_idx", out_idx_a, tbl[i].idx);
      chk("t1_last", out_last_a, tbl[i].last);
      chk("t1_done", done_a, tbl[i].done);
      chk("t1_busy", busy_a, tbl[i].busy);
      step();
    end
    chk("t1_beats", beats, 16);
    chk("t1_done_pulses", done_cnt, 1);

    run_scan("t2", 3, -1);   // long initial stall
    run_scan("t3", 1, -1);   // ready 1010...
    run_scan("t4", 0, 5);    // start re-pulsed mid-scan

    // Reset mid-scan
    sb_reset();
    start_a = 1'b1; out_ready_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_valid", out_valid_a, 0);
    chk("t5_payload", {out_idx_a, out_x_a, out_z_a, out_last_a}, 0);
    chk("t5_addr", rom_addr_a, 0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_quiet_valid", out_valid_a, 0);
    end
    chk("t5_no_done", done_cnt, 0);
    run_scan("t5_rescan", 0, -1);

    for (int k = 0; k < 4; k++) run_scan("rand", 2, -1);

    // Single-point instance
    start_b = 1'b1; out_ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("t6_c1_valid", out_valid_b, 0);
    chk("t6_c1_busy", busy_b, 1);
    @(posedge clk); #1;
    chk("t6_c2_valid", out_valid_b, 1);
    chk("t6_c2_beat", {out_idx_b, out_x_b, out_z_b, out_last_b}, {1'b0, 16'h1000, 16'h2000, 1'b1});
    @(posedge clk); #1;
    chk("t6_c3_done", done_b, 1);
    chk("t6_c3_valid", out_valid_b, 0);
    @(posedge clk); #1;
    chk("t6_c4_busy", busy_b, 0);
    chk("t6_c4_done", done_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
